// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register pending-write counters feeding the decode stall.
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN (a write retiring this cycle is
// readable in the same cycle, so it does not make its register busy).
module register_scoreboard #(
    parameter int unsigned REGISTER_COUNT = 32,
    parameter int unsigned MAX_PENDING    = 3,
    localparam int unsigned ADR_W = $clog2(REGISTER_COUNT),
    localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issueValid,
    input  logic             issueWritesRd,
    input  logic [ADR_W-1:0] issueRdAdr,
    input  logic [ADR_W-1:0] rs1Adr,
    input  logic [ADR_W-1:0] rs2Adr,
    input  logic             rs1Used,
    input  logic             rs2Used,
    input  logic             wbValid,
    input  logic [ADR_W-1:0] wbRdAdr,
    input  logic             killValid,
    input  logic [ADR_W-1:0] killRdAdr,
    output logic             Rs1Busy,
    output logic             Rs2Busy,
    output logic             Stall,
    output logic             IssueAccept,
    output logic             Underflow
);

    logic [CNT_W-1:0] count_q [REGISTER_COUNT];
    logic [CNT_W-1:0] count_d [REGISTER_COUNT];
    logic             underflow_q, underflow_d;
    logic             rs1_busy, rs2_busy, full, stall;

    // Source busy detection; the bypass variant hides a register whose last write retires now.
    always_comb begin
`ifdef SCOREBOARD_WB_BYPASS_EN
        rs1_busy = rs1Used && (count_q[rs1Adr] != '0) &&
                   !(wbValid && (wbRdAdr == rs1Adr) && (count_q[rs1Adr] == CNT_W'(1)));
        rs2_busy = rs2Used && (count_q[rs2Adr] != '0) &&
                   !(wbValid && (wbRdAdr == rs2Adr) && (count_q[rs2Adr] == CNT_W'(1)));
`else
        rs1_busy = rs1Used && (count_q[rs1Adr] != '0);
        rs2_busy = rs2Used && (count_q[rs2Adr] != '0);
`endif
        full  = issueWritesRd && (issueRdAdr != '0) &&
                (count_q[issueRdAdr] == CNT_W'(MAX_PENDING));
        stall = issueValid && (rs1_busy || rs2_busy || full);
    end

    // Outputs are forced low while reset is held.
    always_comb begin
        Rs1Busy     = reset && rs1_busy;
        Rs2Busy     = reset && rs2_busy;
        Stall       = reset && stall;
        IssueAccept = reset && issueValid && !stall;
        Underflow   = underflow_q;
    end

    // Net per-register change: one possible issue, up to two releases, clamped at zero.
    always_comb begin : next_state
        logic [CNT_W+1:0] sum;
        logic [CNT_W+1:0] dec;
        logic             inc;
        underflow_d = underflow_q;
        count_d[0]  = '0;
        for (int unsigned r = 1; r < REGISTER_COUNT; r++) begin
            inc = issueValid && !stall && issueWritesRd && (issueRdAdr == ADR_W'(r));
            dec = {{(CNT_W+1){1'b0}}, wbValid && (wbRdAdr == ADR_W'(r))} +
                  {{(CNT_W+1){1'b0}}, killValid && (killRdAdr == ADR_W'(r))};
            sum = {2'b00, count_q[r]} + {{(CNT_W+1){1'b0}}, inc};
            if (sum < dec) begin
                count_d[r]  = '0;
                underflow_d = 1'b1;
            end else begin
                count_d[r] = CNT_W'(sum - dec);
            end
        end
    end

    // Counter and sticky error state; reset forgets every in-flight write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '{default: '0};
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Per-register pending-write tracker sitting directly upstream of the register file in the Register stage. Decode presents an instruction's source and destination register addresses. The scoreboard counts in-flight writes per architectural register and raises a stall when a source operand is not yet written back. It also stalls when a destination's pending counter is saturated. Writeback and squash release ports retire the outstanding writes; x0 is never tracked.

## Interface
- REGISTER_COUNT, 32, number of architectural registers; address width ADR_W = $clog2(REGISTER_COUNT)
- MAX_PENDING, 3, maximum in-flight writes per register; counter width CNT_W = $clog2(MAX_PENDING+1)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- issueValid  input  1  decode has an instruction this cycle
- issueWritesRd  input  1  the issuing instruction writes a destination register
- issueRdAdr  input  ADR_W  destination register of the issuing instruction
- rs1Adr, rs2Adr  input  ADR_W  source register addresses
- rs1Used, rs2Used  input  1  the source operand is actually read
- wbValid  input  1  writeback retires one write this cycle
- wbRdAdr  input  ADR_W  register being written back
- killValid  input  1  an in-flight instruction with a destination was squashed
- killRdAdr  input  ADR_W  destination of the squashed instruction
- Rs1Busy, Rs2Busy  output  1  the source has an outstanding write
- Stall  output  1  decode must hold; the issue is not accepted
- IssueAccept  output  1  issueValid && !Stall
- Underflow  output  1  sticky error flag: a release hit a zero counter

## Operation
- State is count[1..REGISTER_COUNT-1], each CNT_W bits wide. count[0] is constant 0.
- Definition of busy(a): count[a] != 0, subject to the bypass rule in Configuration.
- Rs1Busy = rs1Used && busy(rs1Adr). Rs2Busy is formed the same way from rs2Used and rs2Adr.
- Definition of full: issueWritesRd && issueRdAdr != 0 && count[issueRdAdr] == MAX_PENDING.
- Stall = issueValid && (Rs1Busy || Rs2Busy || full). Stall is 0 when issueValid is 0.
- Per register r != 0, the counter change on each edge is the sum of three terms:
  - +1 if IssueAccept && issueWritesRd && issueRdAdr == r
  - -1 if wbValid && wbRdAdr == r
  - -1 if killValid && killRdAdr == r
- The net change is applied in one step; for example, an issue plus a writeback to the same r leaves the count unchanged.
- A release whose decrements exceed the current count clamps the counter at 0 and sets Underflow. Underflow is cleared only by reset.
- Releases and issues addressed to x0 are ignored and never set Underflow.
- An increment that would exceed MAX_PENDING cannot occur, because `full` stalls it.

## Timing
- Outputs Stall, IssueAccept, Rs1Busy and Rs2Busy are combinational from the inputs and the current counts. There are zero cycles of latency to stall.
- Counters update on the rising edge of clk. A write accepted at edge N marks the register busy from cycle N+1 onward.
- Reset asserted (low) clears all counts to 0 and Underflow to 0 immediately. While reset is low, Stall, IssueAccept, Rs1Busy and Rs2Busy are 0 and no state changes.
- If reset is asserted mid-operation, every in-flight write is forgotten. Releases arriving after reset deassertion for those writes set Underflow.
- An instruction that reads and writes the same register (rs1Adr == issueRdAdr) checks busy against the pre-issue count.

## Configuration
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: the register file writes on the falling edge, so a value written back in cycle N is readable in the same cycle. In this mode busy(a) = count[a] != 0 && !(wbValid && wbRdAdr == a && count[a] == 1).
- Undefined: busy(a) = count[a] != 0. A source whose last write is retiring this cycle still stalls for one cycle.

## Test plan
- Reset with reset low → every output is 0. Issue an instruction writing x5 (rs1=x0, rs2=x0) → IssueAccept=1 at edge 1 and count[5]=1. Next cycle, an issue with rs1Used and rs1=x5 → Rs1Busy=1 and Stall=1.
- With count[5]=1, assert wbValid with wbRdAdr=5 while an issue reads x5 → with the macro defined, Stall=0; without it, Stall=1 and the next cycle Stall=0.
- Issue three writes to x7 across three cycles (MAX_PENDING=3), then a fourth → Stall=1 on the fourth and count[7] stays 3. Retire one → the fourth is accepted.
- Issue to x9 while wbValid and killValid both target x9, with count[9]=2 → count[9]=1 after the edge. Kill x9 with count[9]=0 → count stays 0 and Underflow=1 and remains 1.
- Issue writing x0 plus a release of x0 → no state change, Underflow=0 and Stall=0. Drive reset low with count[3]=2 → count[3]=0 asynchronously and a later read of x3 does not stall.
